// File: rtl/im_wait_gen.sv
// im_wait_gen: instruction-memory wait-state generator with sequential fast path and stall statistics
// Ports: clk, reset (async, active high); pc fetch address; flush aborts waits and resyncs;
//        stat_clr clears stall_cnt; busy holds fetch; fetch_done pulses after a completed wait;
//        stall_cnt saturating count of busy cycles.
module im_wait_gen #(
  parameter int AW       = 32,
  parameter int MISS_LAT = 4,
  parameter int SEQ_LAT  = 1,
  parameter int SEQ_FAST = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic          flush,
  input  logic          stat_clr,
  output logic          busy,
  output logic          fetch_done,
  output logic [15:0]   stall_cnt
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] tracked_q, tracked_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          fetch_done_q, fetch_done_d;
  logic [15:0]   stall_q, stall_d;
  logic          change, seq;
  logic [3:0]    lat;
  always_comb begin
    change = pc != tracked_q;
    seq = (SEQ_FAST != 0) && (pc == tracked_q + AW'(4));
    busy = !reset && !flush && (state_q == WAIT || change);
    // a redirect mid-wait always pays the full miss latency
    lat = (state_q == IDLE && seq) ? 4'(SEQ_LAT) : 4'(MISS_LAT);
    state_d = state_q;
    tracked_d = tracked_q;
    cnt_d = cnt_q;
    fetch_done_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      tracked_d = pc;
      cnt_d = 4'd0;
    end else if (change) begin
      tracked_d = pc;
      state_d = lat == 4'd1 ? IDLE : WAIT;
      cnt_d = lat == 4'd1 ? 4'd0 : lat - 4'd2;
      fetch_done_d = lat == 4'd1;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? IDLE : WAIT;
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      fetch_done_d = cnt_q == 4'd0;
    end
    stall_d = stat_clr ? 16'd0 : (busy && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tracked_q <= '0;
      cnt_q <= 4'd0;
      fetch_done_q <= 1'b0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      tracked_q <= tracked_d;
      cnt_q <= cnt_d;
      fetch_done_q <= fetch_done_d;
      stall_q <= stall_d;
    end
  end
  assign fetch_done = fetch_done_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_im_wait_gen.sv
// tb_im_wait_gen: directed and randomized checks of im_wait_gen against a cycle-count model
module tb_im_wait_gen;
  localparam int MISS_LAT = 4;
  localparam int SEQ_LAT  = 1;
  logic clk = 1'b0;
  logic reset, flush, stat_clr;
  logic [31:0] pc;
  logic busy, fetch_done, busy2, fetch_done2;
  logic [15:0] stall_cnt, stall_cnt2;
  int vectors = 0;
  int miscompares = 0;
  bit en = 1'b0;
  logic s_busy, s_fd;
  logic [15:0] s_stall;
  int cnt2 = 0;
  logic [31:0] m_tr;
  int m_rem;
  logic m_done;
  logic [15:0] m_stall;
  logic e_busy;
  int e_len;
  im_wait_gen dut (.clk(clk), .reset(reset), .pc(pc), .flush(flush), .stat_clr(stat_clr),
                   .busy(busy), .fetch_done(fetch_done), .stall_cnt(stall_cnt));
  im_wait_gen #(.SEQ_FAST(0)) dut2 (.clk(clk), .reset(reset), .pc(pc), .flush(flush), .stat_clr(stat_clr),
                   .busy(busy2), .fetch_done(fetch_done2), .stall_cnt(stall_cnt2));
  always #5 clk = ~clk;
  // model: m_rem is the number of busy cycles still owed after the current one
  assign e_busy = !reset && !flush && (m_rem != 0 || pc != m_tr);
  assign e_len = (m_rem == 0 && pc == m_tr + 32'd4) ? SEQ_LAT : MISS_LAT;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tr <= 32'd0;
      m_rem <= 0;
      m_done <= 1'b0;
      m_stall <= 16'd0;
    end else begin
      m_stall <= stat_clr ? 16'd0 : (e_busy && m_stall != 16'hFFFF) ? m_stall + 16'd1 : m_stall;
      if (flush) begin
        m_tr <= pc;
        m_rem <= 0;
        m_done <= 1'b0;
      end else if (pc != m_tr) begin
        m_tr <= pc;
        m_rem <= e_len - 1;
        m_done <= e_len == 1;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        m_done <= m_rem == 1;
      end else m_done <= 1'b0;
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (en) begin
    chk("model busy", {31'd0, busy}, {31'd0, e_busy});
    chk("model fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
    chk("model stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
  end
  task automatic cyc(input logic [31:0] p, input logic f, input logic c);
    pc = p;
    flush = f;
    stat_clr = c;
    @(negedge clk);
    s_busy = busy;
    s_fd = fetch_done;
    s_stall = stall_cnt;
    if (busy2) cnt2++;
    @(posedge clk);
    #1;
  endtask
  task automatic pat(input string nm, input logic [31:0] p, input int n, input logic [15:0] eb, input logic [15:0] ef);
    for (int i = 0; i < n; i++) begin
      cyc(p, 1'b0, 1'b0);
      chk({nm, " busy"}, {31'd0, s_busy}, {31'd0, eb[i]});
      chk({nm, " fetch_done"}, {31'd0, s_fd}, {31'd0, ef[i]});
    end
  endtask
  task automatic do_reset();
    pc = 32'd0;
    flush = 1'b0;
    stat_clr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    logic [31:0] tp;
    int r;
    reset = 1'b1;
    pc = 32'd0;
    flush = 1'b0;
    stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    pat("idle", 32'h0, 5, 16'h0, 16'h0);
    chk("idle stall", {16'd0, s_stall}, 32'd0);
    cnt2 = 0;
    pat("miss", 32'h100, 6, 16'b001111, 16'b010000);
    chk("miss stall", {16'd0, s_stall}, 32'd4);
    pat("seq", 32'h104, 6, 16'b000001, 16'b000010);
    chk("seq stall", {16'd0, s_stall}, 32'd5);
    chk("noseq busy cycles", cnt2, 32'd8);
    do_reset();
    cyc(32'h200, 1'b0, 1'b0);
    chk("redir first busy", {31'd0, s_busy}, 32'd1);
    chk("redir first fd", {31'd0, s_fd}, 32'd0);
    pat("redir", 32'h300, 6, 16'b001111, 16'b010000);
    pat("tracked", 32'h300, 2, 16'h0, 16'h0);
    pat("tracked seq", 32'h304, 3, 16'b001, 16'b010);
    chk("redir stall", {16'd0, s_stall}, 32'd6);
    cyc(32'h400, 1'b0, 1'b0);
    chk("flush b0", {31'd0, s_busy}, 32'd1);
    cyc(32'h400, 1'b0, 1'b0);
    chk("flush b1", {31'd0, s_busy}, 32'd1);
    cyc(32'h400, 1'b1, 1'b0);
    chk("flush b2", {31'd0, s_busy}, 32'd0);
    pat("after flush", 32'h400, 5, 16'h0, 16'h0);
    chk("flush stall", {16'd0, s_stall}, 32'd8);
    cyc(32'h500, 1'b0, 1'b0);
    chk("pre-reset busy", {31'd0, s_busy}, 32'd1);
    reset = 1'b1;
    #2;
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async fd", {31'd0, fetch_done}, 32'd0);
    chk("async stall", {16'd0, stall_cnt}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pat("post reset miss", 32'h500, 5, 16'b01111, 16'b10000);
    do_reset();
    cnt2 = 0;
    pat("post reset seq", 32'h4, 6, 16'b000001, 16'b000010);
    chk("post reset noseq cycles", cnt2, 32'd4);
    cyc(32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap flush busy", {31'd0, s_busy}, 32'd0);
    pat("wrap", 32'h0, 3, 16'b001, 16'b010);
    do_reset();
    tp = 32'h1000;
    for (int i = 0; i < 65534; i++) begin
      cyc(tp, 1'b0, 1'b0);
      tp = tp ^ 32'h3000;
    end
    cyc(tp, 1'b0, 1'b0);
    chk("sat fffe", {16'd0, s_stall}, 32'hFFFE);
    chk("sat busy", {31'd0, s_busy}, 32'd1);
    tp = tp ^ 32'h3000;
    cyc(tp, 1'b0, 1'b0);
    chk("sat ffff", {16'd0, s_stall}, 32'hFFFF);
    tp = tp ^ 32'h3000;
    cyc(tp, 1'b0, 1'b0);
    chk("sat hold", {16'd0, s_stall}, 32'hFFFF);
    tp = tp ^ 32'h3000;
    cyc(tp, 1'b0, 1'b1);
    chk("clr busy", {31'd0, s_busy}, 32'd1);
    cyc(tp, 1'b0, 1'b0);
    chk("clr wins", {16'd0, s_stall}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      tp = r < 40 ? m_tr : r < 65 ? m_tr + 32'd4 : r < 85 ? ($urandom & 32'hFFC) : $urandom;
      reset = $urandom_range(0, 99) == 0;
      cyc(tp, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3);
      reset = 1'b0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/im_wait_gen.md
IM_WAIT_GEN -- requirements
Module: im_wait_gen

Interface
REQ-001 Parameter AW, default 32: width of pc.
REQ-002 Parameter MISS_LAT, default 4: busy cycles for a non-sequential PC change; legal range 1..15.
REQ-003 Parameter SEQ_LAT, default 1: busy cycles for a sequential PC change (pc = tracked + 4); legal range 1..MISS_LAT.
REQ-004 Parameter SEQ_FAST, default 1: 1 enables SEQ_LAT; 0 makes every change use MISS_LAT.
REQ-005 Port clk  in  1: single clock; all state updates on posedge.
REQ-006 Port reset  in  1: asynchronous, active-high reset.
REQ-007 Port pc  in  AW: current fetch address.
REQ-008 Port flush  in  1: synchronous abort of any wait; resynchronises the tracked address.
REQ-009 Port stat_clr  in  1: synchronous clear of stall_cnt.
REQ-010 Port busy  out  1: instruction memory not ready; the fetch stage holds.
REQ-011 Port fetch_done  out  1: registered one-cycle pulse after a completed wait.
REQ-012 Port stall_cnt  out  16: saturating count of busy cycles.

Function
REQ-013 Registers: tracked_pc (AW), state {IDLE, WAIT}, cnt (4 bit), fetch_done, stall_cnt.
REQ-014 change = (pc != tracked_pc); seq = SEQ_FAST & (pc == tracked_pc + 4, modulo 2^AW).
REQ-015 busy (combinational) = !reset & !flush & ((state==WAIT) | (state==IDLE & change)); the detection cycle is busy in the same cycle, with zero latency.
REQ-016 IDLE & change & !flush: tracked_pc <= pc; L = seq ? SEQ_LAT : MISS_LAT; if L==1 stay IDLE, else state <= WAIT and cnt <= L-2.
REQ-017 A change therefore yields exactly L consecutive busy cycles, counting the detection cycle.
REQ-018 WAIT & !change: if cnt==0, state <= IDLE; else cnt <= cnt-1.
REQ-019 WAIT & change (redirect mid-wait): tracked_pc <= pc, restart with L = MISS_LAT regardless of seq, and the same L==1 rule as REQ-016.
REQ-020 fetch_done <= 1 for one cycle following the last busy cycle of a wait that was not aborted by flush or redirect; otherwise fetch_done <= 0.
REQ-021 A redirect that restarts the wait does not pulse fetch_done; only the final completion pulses it.
REQ-022 flush=1: state <= IDLE, tracked_pc <= pc, cnt <= 0, fetch_done <= 0; flush overrides change and redirect in the same cycle.
REQ-023 stall_cnt increments by 1 on every cycle with busy=1 and saturates at 16'hFFFF.
REQ-024 stat_clr=1: stall_cnt <= 0; if busy=1 in the same cycle, clear wins and the result is 0.
REQ-025 An unchanged pc in IDLE produces no busy and no state change.
REQ-026 pc wrap: tracked_pc = {AW{1}} - 3 followed by pc = 0 is classified as sequential.

Reset
REQ-027 While reset is high: tracked_pc=0, state=IDLE, cnt=0, fetch_done=0, stall_cnt=0, busy=0, taking effect asynchronously with no clock required.
REQ-028 Reset asserted mid-WAIT abandons the wait; after deassertion, pc != 0 is treated as a non-sequential change unless pc == 4.

Verification
REQ-029 Defaults, reset released with pc=0 held -> busy=0 on every cycle, stall_cnt=0, fetch_done never pulses.
REQ-030 Defaults, pc 0 -> 0x100 held -> busy=1 for exactly 4 cycles, fetch_done=1 on the 5th cycle only, stall_cnt=4.
REQ-031 Defaults, pc 0x100 -> 0x104 -> busy=1 for exactly 1 cycle, fetch_done pulses the next cycle; the same stimulus with SEQ_FAST=0 -> busy for 4 cycles.
REQ-032 Defaults, pc 0 -> 0x200, then pc -> 0x300 on the 2nd busy cycle -> busy for 1+4=5 cycles total, a single fetch_done pulse, tracked_pc=0x300.
REQ-033 Defaults, pc 0 -> 0x400 with flush=1 on the 3rd busy cycle -> busy=0 in that cycle and after, no fetch_done, stall_cnt=2.
REQ-034 stall_cnt preloaded to 0xFFFE by repeated misses -> two further busy cycles leave it at 0xFFFF; stat_clr with busy=1 -> 0.
